// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - sliced valid/ready pipelined add/subtract unit
module pipelined_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             Clk_i,
   input  logic             Reset_ni,
   input  logic             Valid_i,
   output logic             Ready_o,
   input  logic [WIDTH-1:0] Number1_i,
   input  logic [WIDTH-1:0] Number2_i,
   input  logic             Carry_i,
   input  logic             Sub_i,
   output logic             Valid_o,
   input  logic             Ready_i,
   output logic [WIDTH-1:0] Result_o,
   output logic             Carry_o,
   output logic             Overflow_o
);

   localparam int SW = WIDTH / STAGES;

   logic             stall;
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;

   // Subtract is A + ~B + 1, so B is inverted and the carry-in forced at capture.
   always_comb begin
      b_eff   = Sub_i ? ~Number2_i : Number2_i;
      cin_eff = Sub_i | Carry_i;
   end

   // One global stall: everything freezes while the consumer refuses a valid result.
   assign stall   = Valid_o & ~Ready_i;
   assign Ready_o = ~stall;

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      localparam int LO = s * SW;
      localparam int BW = WIDTH - LO;

      logic [WIDTH-1:0] acc_in;
      logic [WIDTH-1:0] acc_d;
      logic [WIDTH-1:0] acc_q;
      logic [BW-1:0]    b_in;
      logic             c_in;
      logic             v_in;
      logic [SW:0]      sum_d;
      logic             c_q;
      logic             v_q;

      // acc carries finished low slices plus still-unused high bits of A.
      if (s == 0) begin : g_src
         assign acc_in = Number1_i;
         assign b_in   = b_eff;
         assign c_in   = cin_eff;
         assign v_in   = Valid_i;
      end else begin : g_src
         assign acc_in = g_stage[s-1].acc_q;
         assign b_in   = g_stage[s-1].g_pass.b_q;
         assign c_in   = g_stage[s-1].c_q;
         assign v_in   = g_stage[s-1].v_q;
      end

      // Ripple only this stage's slice using the carry handed over by the stage before.
      always_comb begin
         sum_d = {1'b0, acc_in[LO +: SW]} + {1'b0, b_in[SW-1:0]} + {{SW{1'b0}}, c_in};
         acc_d = acc_in;
         acc_d[LO +: SW] = sum_d[SW-1:0];
      end

      // Advance a beat or bubble unless stalled; bubbles leave the data registers alone.
      always_ff @(posedge Clk_i or negedge Reset_ni) begin
         if (!Reset_ni) begin
            v_q   <= 1'b0;
            c_q   <= 1'b0;
            acc_q <= '0;
         end else if (!stall) begin
            v_q <= v_in;
            if (v_in) begin
               c_q   <= sum_d[SW];
               acc_q <= acc_d;
            end
         end
      end

      if (s < STAGES - 1) begin : g_pass
         logic [BW-SW-1:0] b_q;

         // Only the B bits of slices not yet added travel on with the beat.
         always_ff @(posedge Clk_i or negedge Reset_ni) begin
            if (!Reset_ni) begin
               b_q <= '0;
            end else if (!stall && v_in) begin
               b_q <= b_in[BW-1:SW];
            end
         end
      end else begin : g_last
         logic ovf_d;
         logic ovf_q;

         // Signed overflow: carry into the MSB differs from the carry out of it.
         assign ovf_d = (acc_in[WIDTH-1] ^ b_in[BW-1] ^ sum_d[SW-1]) ^ sum_d[SW];

         // Overflow flag travels with the last stage's result register.
         always_ff @(posedge Clk_i or negedge Reset_ni) begin
            if (!Reset_ni) begin
               ovf_q <= 1'b0;
            end else if (!stall && v_in) begin
               ovf_q <= ovf_d;
            end
         end
      end
   end

   assign Valid_o    = g_stage[STAGES-1].v_q;
   assign Result_o   = g_stage[STAGES-1].acc_q;
   assign Carry_o    = g_stage[STAGES-1].c_q;
   assign Overflow_o = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - scoreboard bench for pipelined_adder
module tb_pipelined_adder;
   localparam int WIDTH  = 32;
   localparam int STAGES = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_i;
   logic        ready_o;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic        carry_i;
   logic        sub_i;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] result_o;
   logic        carry_o;
   logic        ovf_o;

   typedef struct {
      logic [31:0] r;
      logic        c;
      logic        v;
      int          cyc;
      bit          lat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   lat_mode = 1'b1;
   bit   done = 1'b0;

   pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .Clk_i(clk), .Reset_ni(rst_n), .Valid_i(valid_i), .Ready_o(ready_o),
      .Number1_i(a_i), .Number2_i(b_i), .Carry_i(carry_i), .Sub_i(sub_i),
      .Valid_o(valid_o), .Ready_i(ready_i), .Result_o(result_o),
      .Carry_o(carry_o), .Overflow_o(ovf_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t mk(input logic [31:0] r, input logic c, input logic v);
      exp_t e;
      e.r = r; e.c = c; e.v = v; e.cyc = 0; e.lat = 1'b0;
      return e;
   endfunction

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, input logic sub);
      exp_t        e;
      logic [32:0] s;
      e = mk(32'd0, 1'b0, 1'b0);
      if (sub) begin
         e.r = a - b;
         e.c = (a >= b);
         e.v = (a[31] != b[31]) && (e.r[31] != a[31]);
      end else begin
         s   = {1'b0, a} + {1'b0, b} + 33'(cin);
         e.r = s[31:0];
         e.c = s[32];
         e.v = (a[31] == b[31]) && (e.r[31] != a[31]);
      end
      return e;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
      end
   endtask

   task automatic idle(input int n);
      valid_i = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_x(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input logic sub, input exp_t e);
      bit   rdy;
      int   n;
      exp_t q;
      n = 0;
      q = e;
      valid_i = 1'b1; a_i = a; b_i = b; carry_i = cin; sub_i = sub;
      do begin
         @(negedge clk);
         rdy = ready_o;
         @(posedge clk);
         #1;
         n++;
      end while (!rdy && n < 100);
      if (!rdy) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout actual=no_accept required=accept within 100 cycles");
      end else begin
         q.cyc = cyc;
         q.lat = lat_mode;
         sb.push_back(q);
      end
      valid_i = 1'b0;
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin,
                       input logic sub);
      send_x(a, b, cin, sub, model(a, b, cin, sub));
   endtask

   // Monitor: handshake, stall hold and in-order result checks.
   logic        prev_stall = 1'b0;
   logic [34:0] prev_out = '0;
   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         check("ready_o", 64'(ready_o), 64'(!(valid_o && !ready_i)));
         if (prev_stall)
            check("stall_hold", 64'({valid_o, carry_o, ovf_o, result_o}), 64'(prev_out));
         if (valid_o && ready_i) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat actual=%h required=no beat", result_o);
            end else begin
               e = sb.pop_front();
               check("result", 64'({carry_o, ovf_o, result_o}), 64'({e.c, e.v, e.r}));
               if (e.lat)
                  check("latency", 64'(cyc), 64'(e.cyc + STAGES - 1));
            end
         end
         prev_stall = valid_o && !ready_i;
         prev_out   = {valid_o, carry_o, ovf_o, result_o};
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
      a_i = '0; b_i = '0; carry_i = 1'b0; sub_i = 1'b0;
      #12;
      check("reset_valid", 64'(valid_o), 64'd0);
      check("reset_outs", 64'({carry_o, ovf_o, result_o}), 64'd0);
      check("reset_ready", 64'(ready_o), 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Directed add and subtract corner cases.
      lat_mode = 1'b1;
      send_x(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0));
      send_x(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1));
      send_x(32'd5, 32'd7, 1'b0, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0));
      send_x(32'h8000_0000, 32'h1, 1'b0, 1'b1, mk(32'h7FFF_FFFF, 1'b1, 1'b1));
      send_x(32'd5, 32'd7, 1'b1, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0));
      send_x(32'h8000_0000, 32'h1, 1'b1, 1'b1, mk(32'h7FFF_FFFF, 1'b1, 1'b1));
      send_x(32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, mk(32'h0000_0100, 1'b0, 1'b0));
      idle(6);

      // Back-to-back beats, alternating mode.
      for (int i = 0; i < 8; i++)
         send(32'(i), 32'(16 * i), 1'b0, i[0]);
      idle(6);

      // Gapped input 1,0,0,1.
      send(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
      idle(2);
      send(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1);
      idle(6);

      // Backpressure on a full pipeline.
      lat_mode = 1'b0;
      for (int i = 0; i < 4; i++)
         send($urandom, $urandom, 1'($urandom), 1'($urandom));
      fork
         send($urandom, $urandom, 1'b0, 1'b1);
         begin
            ready_i = 1'b0;
            #1;
            check("stall_ready_low", 64'(ready_o), 64'd0);
            repeat (3) @(posedge clk);
            #1;
            ready_i = 1'b1;
         end
      join
      send($urandom, $urandom, 1'b1, 1'b0);
      idle(8);

      // Random full-rate traffic with random gaps.
      lat_mode = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 3) == 0) idle(1);
         send($urandom, $urandom, 1'($urandom), 1'($urandom));
      end
      idle(6);

      // Random traffic under random backpressure.
      lat_mode = 1'b0;
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               if ($urandom_range(0, 3) == 0) idle(1);
               send($urandom, $urandom, 1'($urandom), 1'($urandom));
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               ready_i = ($urandom_range(0, 3) != 0);
            end
            ready_i = 1'b1;
         end
      join
      ready_i = 1'b1;
      for (int n = 0; n < 200 && sb.size() != 0; n++) begin
         @(posedge clk);
         #1;
      end
      check("drain_backpressure", 64'(sb.size()), 64'd0);

      // Asynchronous reset with beats in flight.
      lat_mode = 1'b1;
      send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
      send(32'h3333_3333, 32'h4444_4444, 1'b0, 1'b1);
      send(32'h5555_5555, 32'h6666_6666, 1'b1, 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", 64'(valid_o), 64'd0);
      check("async_rst_outs", 64'({carry_o, ovf_o, result_o}), 64'd0);
      check("async_rst_ready", 64'(ready_o), 64'd1);
      sb.delete();
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      idle(5);
      send(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b1);
      idle(6);
      check("final_drain", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
